// File: rtl/pipe_alu.sv
// pipe_alu: registered WIDTH-bit ALU for the EX stage with a valid/ready issue handshake.
// Define PIPE_ALU_MULT_EN to build the multi-cycle shift-add unsigned multiplier (op 111).

module pipe_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic [WIDTH-1:0] dataHi,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MULT = 3'b111;

    logic             inv_s;
    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   add_s;
    logic             add_ovf_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_cout_s;
    logic             alu_ovf_s;
    logic             accept_s;

    logic             out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0] data_out_r, data_out_nxt_s;
    logic [WIDTH-1:0] data_hi_r, data_hi_nxt_s;
    logic             zero_r, zero_nxt_s;
    logic             cout_r, cout_nxt_s;
    logic             overflow_r, overflow_nxt_s;

`ifdef PIPE_ALU_MULT_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [WIDTH-1:0]   mcand_r, mcand_nxt_s;
    // Low half starts as the multiplier; each step consumes its LSB as product bits shift in.
    logic [2*WIDTH-1:0] acc_r, acc_nxt_s, acc_step_s;
    logic [WIDTH:0]     upper_sum_s;
    logic [CW-1:0]      cnt_r, cnt_nxt_s;

    assign in_ready = rst_n && (state_r == ST_IDLE);
`else
    assign in_ready = rst_n;
`endif

    assign accept_s = in_valid && in_ready;

    // Single-cycle datapath: shared adder/subtractor plus logic ops.
    always_comb begin
        inv_s      = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU);
        b_eff_s    = dataB ^ {WIDTH{inv_s}};
        add_s      = {1'b0, dataA} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, inv_s};
        add_ovf_s  = (dataA[WIDTH-1] == b_eff_s[WIDTH-1]) &&
                     (add_s[WIDTH-1] != dataA[WIDTH-1]);
        alu_res_s  = {WIDTH{1'b0}};
        alu_cout_s = 1'b0;
        alu_ovf_s  = 1'b0;
        case (op)
            OP_AND:  alu_res_s = dataA & dataB;
            OP_OR:   alu_res_s = dataA | dataB;
            OP_NOR:  alu_res_s = ~(dataA | dataB);
            OP_ADD, OP_SUB: begin
                alu_res_s  = add_s[WIDTH-1:0];
                alu_cout_s = add_s[WIDTH];
                alu_ovf_s  = add_ovf_s;
            end
            OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, add_s[WIDTH-1] ^ add_ovf_s};
            OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, ~add_s[WIDTH]};
            default: alu_res_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef PIPE_ALU_MULT_EN
    // One shift-add step: conditionally add multiplicand into the upper half, then shift right.
    always_comb begin
        upper_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                      (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        acc_step_s  = {upper_sum_s, acc_r[WIDTH-1:1]};
    end
`endif

    // Next-state and next-output selection.
    always_comb begin
        out_valid_nxt_s = 1'b0;
        data_out_nxt_s  = data_out_r;
        data_hi_nxt_s   = data_hi_r;
        zero_nxt_s      = zero_r;
        cout_nxt_s      = cout_r;
        overflow_nxt_s  = overflow_r;
`ifdef PIPE_ALU_MULT_EN
        state_nxt_s = state_r;
        mcand_nxt_s = mcand_r;
        acc_nxt_s   = acc_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (op == OP_MULT)) begin
                    mcand_nxt_s = dataA;
                    acc_nxt_s   = {{WIDTH{1'b0}}, dataB};
                    cnt_nxt_s   = CW'(WIDTH - 1);
                    state_nxt_s = ST_MUL;
                end else if (accept_s) begin
                    out_valid_nxt_s = 1'b1;
                    data_out_nxt_s  = alu_res_s;
                    data_hi_nxt_s   = {WIDTH{1'b0}};
                    zero_nxt_s      = (alu_res_s == {WIDTH{1'b0}});
                    cout_nxt_s      = alu_cout_s;
                    overflow_nxt_s  = alu_ovf_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                acc_nxt_s = acc_step_s;
                if (cnt_r == {CW{1'b0}}) begin
                    out_valid_nxt_s = 1'b1;
                    data_out_nxt_s  = acc_step_s[WIDTH-1:0];
                    data_hi_nxt_s   = acc_step_s[2*WIDTH-1:WIDTH];
                    zero_nxt_s      = (acc_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
                    cout_nxt_s      = 1'b0;
                    overflow_nxt_s  = |acc_step_s[2*WIDTH-1:WIDTH];
                    state_nxt_s     = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
`else
        if (accept_s) begin
            out_valid_nxt_s = 1'b1;
            data_out_nxt_s  = alu_res_s;
            data_hi_nxt_s   = {WIDTH{1'b0}};
            zero_nxt_s      = (alu_res_s == {WIDTH{1'b0}});
            cout_nxt_s      = alu_cout_s;
            overflow_nxt_s  = alu_ovf_s;
        end else begin
            out_valid_nxt_s = 1'b0;
        end
`endif
    end

`ifdef PIPE_ALU_MULT_EN
    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Multiplier working registers; a reset discards any multiply in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            mcand_r <= mcand_nxt_s;
            acc_r   <= acc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end
`endif

    // Result registers; they hold between pulses, only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            data_out_r  <= {WIDTH{1'b0}};
            data_hi_r   <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            cout_r      <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            out_valid_r <= out_valid_nxt_s;
            data_out_r  <= data_out_nxt_s;
            data_hi_r   <= data_hi_nxt_s;
            zero_r      <= zero_nxt_s;
            cout_r      <= cout_nxt_s;
            overflow_r  <= overflow_nxt_s;
        end
    end

    assign out_valid = out_valid_r;
    assign dataOut   = data_out_r;
    assign dataHi    = data_hi_r;
    assign zero      = zero_r;
    assign cout      = cout_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu (WIDTH=32): directed corner cases plus randomized ops
// against an arithmetic reference model; multiplier tests follow PIPE_ALU_MULT_EN.

module tb_pipe_alu;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] out;
        logic [W-1:0] hi;
        logic         z;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] dataA;
    logic [W-1:0] dataB;
    logic         out_valid;
    logic [W-1:0] dataOut;
    logic [W-1:0] dataHi;
    logic         zero;
    logic         cout;
    logic         overflow;
    res_t         got;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .dataOut(dataOut),
        .dataHi(dataHi), .zero(zero), .cout(cout), .overflow(overflow)
    );

    assign got = {dataOut, dataHi, zero, cout, overflow};

    // Directed vectors: ADD ovf, SUB equal, SUB borrow, SLT, SLTU, NOR
    localparam logic [2:0] D_OP [6] = '{3'd2, 3'd4, 3'd4, 3'd3, 3'd6, 3'd5};
    localparam logic [W-1:0] D_A [6] = '{32'h7FFFFFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    localparam logic [W-1:0] D_B [6] = '{32'h00000001, 32'd5, 32'd1, 32'h00000001, 32'h00000001, 32'd0};
    localparam res_t D_EXP [6] = '{
        res_t'({32'h80000000, 32'h0, 1'b0, 1'b0, 1'b1}),
        res_t'({32'h00000000, 32'h0, 1'b1, 1'b1, 1'b0}),
        res_t'({32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0}),
        res_t'({32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0}),
        res_t'({32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0}),
        res_t'({32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0})
    };

    function automatic res_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint sa, sb, sv;
        logic [2*W-1:0] p;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: r.out = a & b;
            3'd1: r.out = a | b;
            3'd5: r.out = ~(a | b);
            3'd2: begin
                p = {{W{1'b0}}, a} + {{W{1'b0}}, b};
                r.out = p[W-1:0];
                r.c = p[W];
                sv = sa + sb;
                r.v = (sv != longint'($signed(r.out)));
            end
            3'd4: begin
                r.out = a - b;
                r.c = (a >= b);
                sv = sa - sb;
                r.v = (sv != longint'($signed(r.out)));
            end
            3'd3: r.out = {{(W-1){1'b0}}, (sa < sb)};
            3'd6: r.out = {{(W-1){1'b0}}, (a < b)};
            default: begin
`ifdef PIPE_ALU_MULT_EN
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                r.out = p[W-1:0];
                r.hi = p[2*W-1:W];
                r.v = (r.hi != '0);
`else
                r.out = '0;
`endif
            end
        endcase
        r.z = (r.out == '0);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'h7FFFFFFF;
            3: return 32'h80000000;
            4: return 32'hFFFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; dataA = '0; dataB = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", in_ready); end
        checks++;
        if ({out_valid, got} !== '0) begin errors++; $display("FAIL reset_outputs: got %b_%h expected all 0", out_valid, got); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_directed();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; op = D_OP[i]; dataA = D_A[i]; dataB = D_B[i];
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b expected 1", i, out_valid); end
            checks++;
            if (got !== D_EXP[i]) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, got, D_EXP[i]); end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || got !== D_EXP[i]) begin
                errors++; $display("FAIL dir%0d_hold: got %b_%h expected 0_%h", i, out_valid, got, D_EXP[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int idx [4] = '{0, 1, 3, 5};
        int hi_cnt = 0;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (out_valid === 1'b1) hi_cnt++;
                checks++;
                if (got !== D_EXP[idx[i-1]]) begin
                    errors++; $display("FAIL b2b%0d_result: got %h expected %h", i - 1, got, D_EXP[idx[i-1]]);
                end
            end
            if (i < 4) begin
                in_valid = 1'b1; op = D_OP[idx[i]]; dataA = D_A[idx[i]]; dataB = D_B[idx[i]];
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (hi_cnt != 4) begin errors++; $display("FAIL b2b_valid_run: got %0d expected 4", hi_cnt); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        logic pending = 1'b0;
        res_t exp_r = '0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== pending) begin errors++; $display("FAIL rnd%0d_valid: got %b expected %b", i, out_valid, pending); end
            if (pending) begin
                checks++;
                if (got !== exp_r) begin errors++; $display("FAIL rnd%0d_result: got %h expected %h", i, got, exp_r); end
            end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: got %b expected 1", i, in_ready); end
            if (i < 300) begin
                in_valid = ($urandom_range(0, 3) != 0);
`ifdef PIPE_ALU_MULT_EN
                op = 3'($urandom_range(0, 6));
`else
                op = 3'($urandom_range(0, 7));
`endif
                dataA = pick(); dataB = pick();
                pending = in_valid;
                exp_r = model(op, dataA, dataB);
            end else begin
                in_valid = 1'b0;
                pending = 1'b0;
            end
        end
    endtask

`ifdef PIPE_ALU_MULT_EN
    task automatic test_mult();
        res_t exp_m = res_t'({32'h0, 32'h1, 1'b1, 1'b0, 1'b1});
        res_t exp_a = res_t'({32'd10, 32'h0, 1'b0, 1'b0, 1'b0});
        int k = 0;
        int low_cnt = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_idle: got %b expected 1", in_ready); end
        in_valid = 1'b1; op = 3'd7; dataA = 32'h00010000; dataB = 32'h00010000;
        checks++;
        if (model(op, dataA, dataB) !== exp_m) begin errors++; $display("FAIL mult_model: got %h expected %h", model(op, dataA, dataB), exp_m); end
        @(negedge clk);
        k = 1;
        op = 3'd2; dataA = 32'd9; dataB = 32'd1;
        while (out_valid !== 1'b1 && k < 100) begin
            if (in_ready === 1'b0) low_cnt++;
            @(negedge clk);
            k++;
        end
        checks++;
        if (k - 1 != W) begin errors++; $display("FAIL mult_latency: got %0d expected %0d", k - 1, W); end
        checks++;
        if (low_cnt != k - 1) begin errors++; $display("FAIL mult_ready_low: got %0d expected %0d", low_cnt, k - 1); end
        checks++;
        if (got !== exp_m) begin errors++; $display("FAIL mult_result: got %h expected %h", got, exp_m); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_ready_back: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || got !== exp_a) begin
            errors++; $display("FAIL mult_next_op: got %b_%h expected 1_%h", out_valid, got, exp_a);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mult_no_queue: got %b expected 0", out_valid); end
    endtask

    task automatic test_mult_abort();
        int seen = 0;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; dataA = 32'd7; dataB = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, got} !== '0) begin errors++; $display("FAIL abort_reset: got %b_%b_%h expected all 0", in_ready, out_valid, got); end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
        in_valid = 1'b1; op = 3'd2; dataA = 32'd2; dataB = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || got !== res_t'({32'd5, 32'h0, 1'b0, 1'b0, 1'b0})) begin
            errors++; $display("FAIL abort_add: got %b_%h expected 1 with dataOut 5", out_valid, got);
        end
    endtask
`else
    task automatic test_mult_disabled();
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; dataA = 32'd3; dataB = 32'd4;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL nomul_ready0: got %b expected 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || got !== res_t'({32'h0, 32'h0, 1'b1, 1'b0, 1'b0})) begin
            errors++; $display("FAIL nomul_result: got %b_%h expected 1 with zero set", out_valid, got);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL nomul_ready1: got %b expected 1", in_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
`ifdef PIPE_ALU_MULT_EN
        test_mult();
        test_mult_abort();
`else
        test_mult_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
